reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer between the issue stage and the register file. It allocates one entry per issued instruction and absorbs out-of-order results from the reservation-station and store/load-buffer writeback ports. It retires entries strictly in program order, one per cycle, broadcasting each committed value to RS/SLB and the register file. It detects branch and JALR mispredictions at commit and raises the pipeline-wide flush.

## Interface
- ROB_SIZE, 16, entry count; power of two, ≥4
- IDX_W, 4, log2(ROB_SIZE)
- XLEN, 32, data width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  issue requests an entry
- alloc_ready  out  1  entry available (count < ROB_SIZE)
- alloc_idx  out  IDX_W  index the request receives (= tail)
- alloc_kind  in  2  0 REG, 1 BRANCH, 2 JALR, 3 STORE
- alloc_rd  in  5  destination register
- alloc_pred_taken  in  1  frontend's branch prediction
- alloc_alt_pc  in  XLEN  PC of the path not predicted (BRANCH only)
- rs_wb_valid / rs_wb_idx / rs_wb_value / rs_wb_jumppc  in  1/IDX_W/XLEN/XLEN  RS result
- slb_wb_valid / slb_wb_idx / slb_wb_value  in  1/IDX_W/XLEN  load value or store-address-ready
- q1_idx, q2_idx  in  IDX_W  operand lookup indices from issue
- q1_ready, q2_ready  out  1  entry result present (combinational from stored state)
- q1_value, q2_value  out  XLEN  stored result
- commit_valid  out  1  registered pulse: an entry retired
- commit_idx  out  IDX_W  retired index (RS/SLB tag match)
- commit_rd  out  5  register-file write address
- commit_value  out  XLEN  register-file and RS/SLB broadcast value
- commit_wen  out  1  register write (kind REG or JALR)
- store_commit  out  1  registered pulse: SLB may perform head store
- flush  out  1  registered pulse: discard all speculative state
- flush_pc  out  XLEN  redirect target

## Operation
- Per-entry state: busy, ready, kind, rd, pred_taken, alt_pc, value, jumppc. Pointers: head, tail (IDX_W bits, wrap mod ROB_SIZE). Count is IDX_W+1 bits.
- Allocate when alloc_valid && alloc_ready: entry[tail] gets busy=1, ready=0, and the fields; tail+1; count+1. alloc_valid while full is ignored.
- RS writeback: entry[rs_wb_idx] gets ready=1, value, jumppc.
- SLB writeback: entry[slb_wb_idx] gets ready=1, value.
- Writebacks to non-busy entries are ignored. RS and SLB writebacks to distinct indices in one cycle are both applied. The same index in one cycle is illegal.
- Commit when entry[head] is busy and ready. Entry cleared, head+1, count−1. Registered outputs are loaded from the entry.
  - REG: commit_wen=1, commit_value=value.
  - JALR: commit_wen=1, commit_value=value (pc+4). Always redirects: flush=1, flush_pc=jumppc.
  - BRANCH: commit_wen=0. Actual taken is value[0]. If it differs from pred_taken: flush=1, flush_pc=alt_pc.
  - STORE: commit_wen=0, store_commit=1.
- Flush edge, i.e. the edge at which a redirecting entry commits:
  - All entries become non-busy; head=tail=count=0.
  - Same-cycle allocation and writebacks are dropped.
  - alloc_idx reads 0 next cycle.
- Allocate and commit in the same cycle without a flush: count unchanged. Allowed even when full; alloc_ready still reads 0 when full, so no allocation occurs.

## Timing
- Reset values: every registered output 0, all entries non-busy, head=tail=count=0. alloc_ready=1 and alloc_idx=0 after reset.
- All state updates on posedge clk. rst has priority over rdy.
- rdy=0 at an edge:
  - State holds.
  - commit_valid, store_commit and flush read 0 in the following cycle.
- Pulse outputs last one cycle.
- Latency:
  - Allocation at edge N, writeback presented in cycle after N, so sampled at edge N+1.
  - Commit happens at edge N+2; commit_valid is high in the cycle after N+2.
  - Minimum alloc-to-commit is 2 edges.
- q*_ready/q*_value reflect state after the last edge; no same-cycle writeback bypass.
- alloc_ready and alloc_idx are combinational from the current count and tail.
- Wrap: tail ROB_SIZE−1 → 0 with head non-zero works; full detected by count, never by pointer equality.

## Test plan
- Reset, then allocate REG rd=5 (idx 0). RS writes back idx 0 value 0x1234. → commit_valid=1, commit_rd=5, commit_value=0x1234, commit_wen=1 two edges after allocation.
- Allocate idx 0,1,2. Writebacks arrive in order 2,0,1. → commits occur in order 0,1,2; idx 2 retires only after idx 1's writeback.
- Fill 16 entries. → alloc_ready=0; a 17th alloc_valid is ignored. Commit one entry → alloc_ready=1. Next allocation gets idx 0 after tail has wrapped.
- BRANCH with pred_taken=0, alt_pc=0x100, writeback value=1, followed by two younger REG entries with writebacks. → flush=1, flush_pc=0x100; younger entries never commit; alloc_idx=0 next cycle.
- JALR writeback value 0x1008, jumppc 0x2000. → commit_wen=1, commit_value=0x1008, flush=1, flush_pc=0x2000.
- STORE with SLB writeback, then rdy=0 for 3 cycles. → no pulses and state frozen; store_commit=1 at the first edge after rdy returns.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates in program order, absorbs out-of-order
// writebacks, retires one entry per cycle and raises flush on redirecting commits.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int IDX_W    = 4,
  parameter int XLEN     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic [1:0]       alloc_kind,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_pred_taken,
  input  logic [XLEN-1:0]  alloc_alt_pc,
  input  logic             rs_wb_valid,
  input  logic [IDX_W-1:0] rs_wb_idx,
  input  logic [XLEN-1:0]  rs_wb_value,
  input  logic [XLEN-1:0]  rs_wb_jumppc,
  input  logic             slb_wb_valid,
  input  logic [IDX_W-1:0] slb_wb_idx,
  input  logic [XLEN-1:0]  slb_wb_value,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [XLEN-1:0]  q1_value,
  output logic [XLEN-1:0]  q2_value,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_idx,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic             commit_wen,
  output logic             store_commit,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc
);

  localparam logic [1:0] K_REG    = 2'd0;
  localparam logic [1:0] K_BRANCH = 2'd1;
  localparam logic [1:0] K_JALR   = 2'd2;
  localparam logic [1:0] K_STORE  = 2'd3;

  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  logic [1:0]          kind       [ROB_SIZE];
  logic [4:0]          rd         [ROB_SIZE];
  logic                pred_taken [ROB_SIZE];
  logic [XLEN-1:0]     alt_pc     [ROB_SIZE];
  logic [XLEN-1:0]     value      [ROB_SIZE];
  logic [XLEN-1:0]     jumppc     [ROB_SIZE];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  logic       do_alloc;
  logic       do_commit;
  logic       redirect;
  logic       rs_hit;
  logic       slb_hit;
  logic [1:0] head_kind;

  function automatic logic writes_rd(input logic [1:0] k);
    return (k == K_REG) || (k == K_JALR);
  endfunction

  // count never exceeds ROB_SIZE, so its MSB alone marks the buffer full
  assign alloc_ready = ~count[IDX_W];
  assign alloc_idx   = tail;

  assign q1_ready = ready[q1_idx];
  assign q2_ready = ready[q2_idx];
  assign q1_value = value[q1_idx];
  assign q2_value = value[q2_idx];

  always_comb begin
    head_kind = kind[head];
    do_alloc  = alloc_valid && alloc_ready;
    do_commit = busy[head] && ready[head];
    rs_hit    = rs_wb_valid && busy[rs_wb_idx];
    slb_hit   = slb_wb_valid && busy[slb_wb_idx];
    redirect  = do_commit &&
                ((head_kind == K_JALR) ||
                 ((head_kind == K_BRANCH) && (value[head][0] != pred_taken[head])));
  end

  // control state and registered commit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_idx   <= '0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_wen   <= 1'b0;
      store_commit <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      commit_wen   <= 1'b0;
      store_commit <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      commit_wen   <= do_commit && writes_rd(head_kind);
      store_commit <= do_commit && (head_kind == K_STORE);
      flush        <= redirect;
      if (do_commit) begin
        commit_idx   <= head;
        commit_rd    <= rd[head];
        commit_value <= value[head];
      end
      if (redirect)
        flush_pc <= (head_kind == K_JALR) ? jumppc[head] : alt_pc[head];

      if (redirect) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (rs_hit)  ready[rs_wb_idx]  <= 1'b1;
        if (slb_hit) ready[slb_wb_idx] <= 1'b1;
        // commit clears after the writeback updates so a stale write cannot revive it
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + IDX_W'(1);
        end
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + IDX_W'(1);
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + (IDX_W+1)'(1);
          2'b01:   count <= count - (IDX_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // entry payload; only meaningful while busy, so it needs no reset
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (do_alloc) begin
        kind[tail]       <= alloc_kind;
        rd[tail]         <= alloc_rd;
        pred_taken[tail] <= alloc_pred_taken;
        alt_pc[tail]     <= alloc_alt_pc;
      end
      if (rs_hit) begin
        value[rs_wb_idx]  <= rs_wb_value;
        jumppc[rs_wb_idx] <= rs_wb_jumppc;
      end
      if (slb_hit)
        value[slb_wb_idx] <= slb_wb_value;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits queued in program order,
// a negedge monitor pops and compares every commit pulse.
module tb_reorder_buffer;
  localparam int ROB_SIZE = 16;
  localparam int IDX_W    = 4;
  localparam int XLEN     = 32;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic [1:0]       alloc_kind;
  logic [4:0]       alloc_rd;
  logic             alloc_pred_taken;
  logic [XLEN-1:0]  alloc_alt_pc;
  logic             rs_wb_valid;
  logic [IDX_W-1:0] rs_wb_idx;
  logic [XLEN-1:0]  rs_wb_value;
  logic [XLEN-1:0]  rs_wb_jumppc;
  logic             slb_wb_valid;
  logic [IDX_W-1:0] slb_wb_idx;
  logic [XLEN-1:0]  slb_wb_value;
  logic [IDX_W-1:0] q1_idx;
  logic [IDX_W-1:0] q2_idx;
  logic             q1_ready;
  logic             q2_ready;
  logic [XLEN-1:0]  q1_value;
  logic [XLEN-1:0]  q2_value;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_idx;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_value;
  logic             commit_wen;
  logic             store_commit;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_pred_taken(alloc_pred_taken),
    .alloc_alt_pc(alloc_alt_pc),
    .rs_wb_valid(rs_wb_valid), .rs_wb_idx(rs_wb_idx), .rs_wb_value(rs_wb_value),
    .rs_wb_jumppc(rs_wb_jumppc),
    .slb_wb_valid(slb_wb_valid), .slb_wb_idx(slb_wb_idx), .slb_wb_value(slb_wb_value),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_wen(commit_wen), .store_commit(store_commit),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [4:0]       rd;
    logic [XLEN-1:0]  value;
    logic             wen;
    logic             store;
    logic             flsh;
    logic [XLEN-1:0]  fpc;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_commit(input int idx, input int r, input logic [XLEN-1:0] v,
                               input logic w, input logic s, input logic f,
                               input logic [XLEN-1:0] pc);
    exp_t e;
    e.idx = IDX_W'(idx); e.rd = 5'(r); e.value = v;
    e.wen = w; e.store = s; e.flsh = f; e.fpc = pc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic alloc(input logic [1:0] k, input int r, input logic p, input logic [XLEN-1:0] a);
    alloc_valid = 1'b1; alloc_kind = k; alloc_rd = 5'(r);
    alloc_pred_taken = p; alloc_alt_pc = a;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic rv, input int ri, input logic [XLEN-1:0] rval,
                    input logic [XLEN-1:0] rjpc,
                    input logic sv, input int si, input logic [XLEN-1:0] sval);
    rs_wb_valid = rv; rs_wb_idx = IDX_W'(ri); rs_wb_value = rval; rs_wb_jumppc = rjpc;
    slb_wb_valid = sv; slb_wb_idx = IDX_W'(si); slb_wb_value = sval;
    tick();
    rs_wb_valid = 1'b0; slb_wb_valid = 1'b0;
  endtask

  // monitor: every commit pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (commit_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_commit: got idx %0d value 0x%0h, required no commit",
                   commit_idx, commit_value);
        end else begin
          e = sb.pop_front();
          if (commit_idx !== e.idx || commit_rd !== e.rd || commit_value !== e.value ||
              commit_wen !== e.wen || store_commit !== e.store || flush !== e.flsh ||
              (e.flsh && flush_pc !== e.fpc)) begin
            fails++;
            $display("FAIL commit: got idx=%0d rd=%0d val=0x%0h wen=%0b st=%0b fl=%0b pc=0x%0h, required idx=%0d rd=%0d val=0x%0h wen=%0b st=%0b fl=%0b pc=0x%0h",
                     commit_idx, commit_rd, commit_value, commit_wen, store_commit, flush, flush_pc,
                     e.idx, e.rd, e.value, e.wen, e.store, e.flsh, e.fpc);
          end
        end
      end else if (flush || store_commit || commit_wen) begin
        tests++;
        fails++;
        $display("FAIL stray_pulse: got flush=%0b store=%0b wen=%0b, required all 0",
                 flush, store_commit, commit_wen);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    alloc_valid = 1'b0; alloc_kind = 2'd0; alloc_rd = 5'd0;
    alloc_pred_taken = 1'b0; alloc_alt_pc = '0;
    rs_wb_valid = 1'b0; rs_wb_idx = '0; rs_wb_value = '0; rs_wb_jumppc = '0;
    slb_wb_valid = 1'b0; slb_wb_idx = '0; slb_wb_value = '0;
    q1_idx = '0; q2_idx = '0;
    tick_n(2);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_flush_pc", flush_pc, 32'd0);
    check("rst_commit_value", commit_value, 32'd0);
    rst = 1'b0;
    tick();

    // basic REG allocate, writeback, commit two edges later
    expect_commit(0, 5, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0);
    alloc(2'd0, 5, 1'b0, 32'h0);
    wb(1'b1, 0, 32'h1234, 32'h0, 1'b0, 0, 32'h0);
    check("lat_no_commit_yet", 32'(commit_valid), 32'd0);
    check("q1_ready_after_wb", 32'(q1_ready), 32'd1);
    check("q2_value_after_wb", q2_value, 32'h1234);
    tick();
    check("lat_commit_valid", 32'(commit_valid), 32'd1);
    check("lat_commit_rd", 32'(commit_rd), 32'd5);
    check("lat_commit_value", commit_value, 32'h1234);
    check("q1_ready_after_commit", 32'(q1_ready), 32'd0);

    // out-of-order writebacks 3,1,2 retire as 1,2,3
    check("ooo_first_idx", 32'(alloc_idx), 32'd1);
    expect_commit(1, 1, 32'h11, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_commit(2, 2, 32'h22, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_commit(3, 3, 32'h33, 1'b1, 1'b0, 1'b0, 32'h0);
    alloc(2'd0, 1, 1'b0, 32'h0);
    alloc(2'd0, 2, 1'b0, 32'h0);
    alloc(2'd0, 3, 1'b0, 32'h0);
    wb(1'b1, 3, 32'h33, 32'h0, 1'b0, 0, 32'h0);
    tick();
    check("ooo_head_blocked", 32'(commit_valid), 32'd0);
    wb(1'b1, 1, 32'h11, 32'h0, 1'b0, 0, 32'h0);
    wb(1'b0, 0, 32'h0, 32'h0, 1'b1, 2, 32'h22);
    tick_n(4);
    check("ooo_drained", 32'(sb.size()), 32'd0);

    // fill from a fresh reset, overflow attempt, wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      expect_commit(i, i, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 32'h0);
      alloc(2'd0, i, 1'b0, 32'h0);
    end
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    alloc(2'd0, 9, 1'b0, 32'h0);
    check("full_ignored_ready", 32'(alloc_ready), 32'd0);
    check("full_ignored_idx", 32'(alloc_idx), 32'd0);
    wb(1'b1, 0, 32'h100, 32'h0, 1'b0, 0, 32'h0);
    tick();
    check("after_commit_ready", 32'(alloc_ready), 32'd1);
    check("wrap_alloc_idx", 32'(alloc_idx), 32'd0);
    expect_commit(0, 31, 32'hAAA, 1'b1, 1'b0, 1'b0, 32'h0);
    alloc(2'd0, 31, 1'b0, 32'h0);
    for (int i = 1; i < ROB_SIZE; i += 2) begin
      if (i + 1 == ROB_SIZE)
        wb(1'b1, i, 32'h100 + 32'(i), 32'h0, 1'b1, 0, 32'hAAA);
      else
        wb(1'b1, i, 32'h100 + 32'(i), 32'h0, 1'b1, i + 1, 32'h100 + 32'(i + 1));
    end
    tick_n(20);
    check("wrap_drained", 32'(sb.size()), 32'd0);

    // mispredicted branch squashes younger entries and a same-cycle alloc
    expect_commit(1, 0, 32'h1, 1'b0, 1'b0, 1'b1, 32'h100);
    alloc(2'd1, 0, 1'b0, 32'h100);
    alloc(2'd0, 7, 1'b0, 32'h0);
    alloc(2'd0, 8, 1'b0, 32'h0);
    wb(1'b1, 2, 32'h22, 32'h0, 1'b1, 3, 32'h33);
    wb(1'b1, 1, 32'h1, 32'h0, 1'b0, 0, 32'h0);
    q1_idx = 4'd2;
    alloc(2'd0, 9, 1'b0, 32'h0);
    check("br_flush", 32'(flush), 32'd1);
    check("br_flush_pc", flush_pc, 32'h100);
    check("br_alloc_idx", 32'(alloc_idx), 32'd0);
    check("br_young_cleared", 32'(q1_ready), 32'd0);
    tick_n(4);
    check("br_drained", 32'(sb.size()), 32'd0);

    // correct branch then JALR
    expect_commit(0, 0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_commit(1, 1, 32'h1008, 1'b1, 1'b0, 1'b1, 32'h2000);
    alloc(2'd1, 0, 1'b1, 32'h500);
    alloc(2'd2, 1, 1'b0, 32'h0);
    wb(1'b1, 1, 32'h1008, 32'h2000, 1'b1, 0, 32'h1);
    tick_n(2);
    check("jalr_flush", 32'(flush), 32'd1);
    check("jalr_flush_pc", flush_pc, 32'h2000);
    check("jalr_wen", 32'(commit_wen), 32'd1);
    check("jalr_value", commit_value, 32'h1008);
    tick();
    check("jalr_alloc_idx", 32'(alloc_idx), 32'd0);

    // store held by rdy=0 for three edges
    expect_commit(0, 0, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
    alloc(2'd3, 0, 1'b0, 32'h0);
    wb(1'b0, 0, 32'h0, 32'h0, 1'b1, 0, 32'h40);
    rdy = 1'b0;
    q1_idx = 4'd0;
    alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_no_commit", 32'(commit_valid), 32'd0);
      check("frz_no_store", 32'(store_commit), 32'd0);
      check("frz_q1_ready", 32'(q1_ready), 32'd1);
      check("frz_alloc_idx", 32'(alloc_idx), 32'd1);
    end
    alloc_valid = 1'b0;
    rdy = 1'b1;
    tick();
    check("st_store_commit", 32'(store_commit), 32'd1);
    check("st_commit_valid", 32'(commit_valid), 32'd1);
    tick();
    check("st_pulse_once", 32'(store_commit), 32'd0);
    check("st_alloc_idx", 32'(alloc_idx), 32'd1);
    tick_n(2);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
